// File: rtl/axil_slave_regfile.sv
// AXI-Lite slave register file: NUM_REGS registers at BASE_ADDR with byte strobes,
// read-only status registers and per-register write pulses; independent read/write FSMs.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order), commit when both available
// W_RESP | holding B response until bready
// R_IDLE | accepting AR
// R_DATA | holding R response until rready
module axil_slave_regfile #(
  parameter int                          AXI_DATA_WIDTH = 32,
  parameter int                          AXI_ADDR_WIDTH = 32,
  parameter int                          NUM_REGS       = 8,
  parameter logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
  parameter logic [NUM_REGS-1:0]         RO_MASK        = '0,
  parameter logic [AXI_DATA_WIDTH-1:0]   RESET_VAL      = '0
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic                               s_axil_awvalid,
  output logic                               s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]        s_axil_wstrb,
  input  logic                               s_axil_wvalid,
  output logic                               s_axil_wready,
  output logic [1:0]                         s_axil_bresp,
  output logic                               s_axil_bvalid,
  input  logic                               s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic                               s_axil_arvalid,
  output logic                               s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                         s_axil_rresp,
  output logic                               s_axil_rvalid,
  input  logic                               s_axil_rready,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                reg_wr_pulse,
  input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] status_in
);
  localparam int DW     = AXI_DATA_WIDTH;
  localparam int AW     = AXI_ADDR_WIDTH;
  localparam int SW     = DW / 8;
  localparam int OFF_SH = $clog2(SW);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [AW-1:0] REG_SPAN = AW'(NUM_REGS * SW);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic                          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AW-1:0]                 awaddr_q, awaddr_d;
  logic [DW-1:0]                 wdata_q, wdata_d;
  logic [SW-1:0]                 wstrb_q, wstrb_d;
  logic                          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]                    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0]                 rdata_q, rdata_d;
  logic [NUM_REGS-1:0][DW-1:0]   regs_q, regs_d, status_arr;
  logic [NUM_REGS-1:0]           wr_pulse_q, wr_pulse_d;

  logic          aw_hs, w_hs, ar_hs;
  logic [AW-1:0] wr_addr, wr_off, rd_off;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          wr_hit, rd_hit;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign status_arr     = status_in;
  assign reg_q          = regs_q;
  assign reg_wr_pulse   = wr_pulse_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;

  // Readies depend only on state flops and reset, never on the valid inputs.
  assign s_axil_awready = !areset && (w_state_q == W_IDLE) && !aw_held_q;
  assign s_axil_wready  = !areset && (w_state_q == W_IDLE) && !w_held_q;
  assign s_axil_arready = !areset && (r_state_q == R_IDLE);

  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid && s_axil_wready;
  assign ar_hs = s_axil_arvalid && s_axil_arready;

  always_comb begin
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    wr_addr    = aw_held_q ? awaddr_q : s_axil_awaddr;
    wr_data    = w_held_q ? wdata_q : s_axil_wdata;
    wr_strb    = w_held_q ? wstrb_q : s_axil_wstrb;
    wr_off     = wr_addr - BASE_ADDR;
    wr_hit     = wr_off < REG_SPAN;
    wr_idx     = wr_off[OFF_SH +: IDX_W];
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axil_awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axil_wdata;
          wstrb_d  = s_axil_wstrb;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
          if (wr_hit && !RO_MASK[wr_idx]) begin
            for (int b = 0; b < SW; b++) begin
              if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
            end
            wr_pulse_d[wr_idx] = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Reads sample regs_q, so a same-edge write commit is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rd_off    = s_axil_araddr - BASE_ADDR;
    rd_hit    = rd_off < REG_SPAN;
    rd_idx    = rd_off[OFF_SH +: IDX_W];
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          if (!rd_hit)               rdata_d = '0;
          else if (RO_MASK[rd_idx])  rdata_d = status_arr[rd_idx];
          else                       rdata_d = regs_q[rd_idx];
          rresp_d   = rd_hit ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axil_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      regs_q     <= {NUM_REGS{RESET_VAL}};
      wr_pulse_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end
endmodule

// File: tb/tb_axil_slave_regfile.sv
// Testbench for axil_slave_regfile: directed vector table, multi-cycle corner sequences
// and randomized traffic checked against an array-based register model.
module tb_axil_slave_regfile;
  localparam int NR = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [NR-1:0] RO = 8'h04;
  localparam logic [31:0] RST = 32'h0;

  logic aclk = 1'b0, areset = 1'b1;
  logic [31:0] s_axil_awaddr = '0, s_axil_wdata = '0, s_axil_araddr = '0, s_axil_rdata;
  logic [3:0]  s_axil_wstrb = '0;
  logic s_axil_awvalid = 0, s_axil_wvalid = 0, s_axil_bready = 0, s_axil_arvalid = 0, s_axil_rready = 0;
  logic s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0] s_axil_bresp, s_axil_rresp;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0] reg_wr_pulse;
  logic [NR-1:0][31:0] status_p, m_regs;

  int checks = 0, errors = 0;

  axil_slave_regfile #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .NUM_REGS(NR),
                       .BASE_ADDR(BASE), .RO_MASK(RO), .RESET_VAL(RST)) dut (
    .aclk(aclk), .areset(areset),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .status_in(status_p));

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name);
    checks++;
    if (reg_q !== m_regs) begin
      errors++;
      $display("FAIL %s: reg_q got 0x%h expected 0x%h", name, reg_q, m_regs);
    end
  endtask

  // Reference model: byte-addressed window of NR words starting at BASE.
  task automatic m_decode(input logic [31:0] addr, output bit inr, output int idx);
    logic [31:0] off;
    off = addr - BASE;
    inr = off < NR * 4;
    idx = inr ? int'(off / 4) : 0;
  endtask

  task automatic m_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         output logic [1:0] resp, output logic [NR-1:0] pulse);
    bit inr; int idx;
    m_decode(addr, inr, idx);
    pulse = '0;
    resp = inr ? 2'b00 : 2'b10;
    if (inr && !RO[idx]) begin
      for (int b = 0; b < 4; b++) if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
      pulse[idx] = 1'b1;
    end
  endtask

  task automatic m_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit inr; int idx;
    m_decode(addr, inr, idx);
    resp = inr ? 2'b00 : 2'b10;
    data = !inr ? 32'h0 : (RO[idx] ? status_p[idx] : m_regs[idx]);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output logic [NR-1:0] pulse_seen,
                           output int pulse_cycles, output int lat);
    int cyc, hs; bit aw_f, w_f, b_f, aw_done, w_done, done, first;
    cyc = 0; hs = 0; aw_f = 0; w_f = 0; b_f = 0; aw_done = 0; w_done = 0; done = 0; first = 1;
    resp = 2'b11; pulse_seen = '0; pulse_cycles = 0; lat = -1;
    s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
    while (!done) begin
      @(negedge aclk);
      if (reg_wr_pulse != 0) begin pulse_cycles++; pulse_seen |= reg_wr_pulse; end
      if (aw_f) begin aw_done = 1; s_axil_awvalid = 0; aw_f = 0; end
      if (w_f) begin w_done = 1; s_axil_wvalid = 0; w_f = 0; end
      if (b_f) begin
        done = 1; s_axil_bready = 0;
        chk("bvalid_drop", s_axil_bvalid, 0);
      end else begin
        if (s_axil_bvalid && first) begin first = 0; lat = cyc - hs; end
        if (!aw_done && cyc >= aw_dly) s_axil_awvalid = 1;
        if (!w_done && cyc >= w_dly) s_axil_wvalid = 1;
        s_axil_bready = (cyc >= b_dly);
        aw_f = s_axil_awvalid && s_axil_awready;
        w_f  = s_axil_wvalid && s_axil_wready;
        if (aw_f || w_f) hs = cyc;
        b_f = s_axil_bvalid && s_axil_bready;
        if (b_f) resp = s_axil_bresp;
        cyc++;
        if (cyc > 200) begin
          checks++; errors++;
          $display("FAIL wr_timeout: got no B response expected one within 200 cycles");
          done = 1; s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_bready = 0;
        end
      end
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
    int cyc, hs; bit ar_f, r_f, ar_done, done, first;
    cyc = 0; hs = 0; ar_f = 0; r_f = 0; ar_done = 0; done = 0; first = 1;
    data = 32'hxxxx_xxxx; resp = 2'b11; lat = -1;
    s_axil_araddr = addr;
    while (!done) begin
      @(negedge aclk);
      if (ar_f) begin ar_done = 1; s_axil_arvalid = 0; ar_f = 0; end
      if (r_f) begin
        done = 1; s_axil_rready = 0;
        chk("rvalid_drop", s_axil_rvalid, 0);
      end else begin
        if (s_axil_rvalid && first) begin first = 0; lat = cyc - hs; end
        if (!ar_done && cyc >= ar_dly) s_axil_arvalid = 1;
        s_axil_rready = (cyc >= r_dly);
        ar_f = s_axil_arvalid && s_axil_arready;
        if (ar_f) hs = cyc;
        r_f = s_axil_rvalid && s_axil_rready;
        if (r_f) begin data = s_axil_rdata; resp = s_axil_rresp; end
        cyc++;
        if (cyc > 200) begin
          checks++; errors++;
          $display("FAIL rd_timeout: got no R response expected one within 200 cycles");
          done = 1; s_axil_arvalid = 0; s_axil_rready = 0;
        end
      end
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd, input int bd,
                          output logic [1:0] resp, output logic [NR-1:0] pulse);
    logic [1:0] eresp; logic [NR-1:0] epulse; int pcyc, lat;
    m_write(addr, data, strb, eresp, epulse);
    axi_write(addr, data, strb, awd, wd, bd, resp, pulse, pcyc, lat);
    chk("wr_bresp", resp, eresp);
    chk("wr_pulse", pulse, epulse);
    chk("wr_pulse_cycles", pcyc, (epulse != 0) ? 1 : 0);
    chk("wr_latency", lat, 1);
    chk_regs("wr_regs");
  endtask

  task automatic do_read(input logic [31:0] addr, input int ard, input int rd,
                         output logic [31:0] data, output logic [1:0] resp);
    logic [31:0] edata; logic [1:0] eresp; int lat;
    m_read(addr, edata, eresp);
    axi_read(addr, ard, rd, data, resp, lat);
    chk("rd_data", data, edata);
    chk("rd_resp", resp, eresp);
    chk("rd_latency", lat, 1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  exp_resp;
    bit          chk_val;
    int          idx;
    logic [31:0] exp_val;
    logic [NR-1:0] exp_pulse;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] d, ed; logic [1:0] r, er; logic [NR-1:0] p, ep;

    tbl[0]  = '{1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 1'b1, 1, 32'hDEADBEEF, 8'h02};
    tbl[1]  = '{1'b0, 32'h1004, 32'h0,        4'h0, 0, 0, 2'b00, 1'b1, 1, 32'hDEADBEEF, 8'h00};
    tbl[2]  = '{1'b1, 32'h1004, 32'h12345678, 4'h3, 3, 0, 2'b00, 1'b1, 1, 32'hDEAD5678, 8'h02};
    tbl[3]  = '{1'b0, 32'h1004, 32'h0,        4'h0, 1, 0, 2'b00, 1'b1, 1, 32'hDEAD5678, 8'h00};
    tbl[4]  = '{1'b0, 32'h1020, 32'h0,        4'h0, 0, 0, 2'b10, 1'b1, 0, 32'h0,        8'h00};
    tbl[5]  = '{1'b1, 32'h1020, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10, 1'b0, 0, 32'h0,        8'h00};
    tbl[6]  = '{1'b1, 32'h1008, 32'h0,        4'hF, 0, 0, 2'b00, 1'b1, 2, 32'h0,        8'h00};
    tbl[7]  = '{1'b0, 32'h1008, 32'h0,        4'h0, 0, 0, 2'b00, 1'b1, 2, 32'hA5A5A5A5, 8'h00};
    tbl[8]  = '{1'b1, 32'h101C, 32'hCAFEF00D, 4'hC, 0, 2, 2'b00, 1'b1, 7, 32'hCAFE0000, 8'h80};
    tbl[9]  = '{1'b0, 32'h101E, 32'h0,        4'h0, 0, 0, 2'b00, 1'b1, 7, 32'hCAFE0000, 8'h00};
    tbl[10] = '{1'b0, 32'h0FFC, 32'h0,        4'h0, 0, 0, 2'b10, 1'b1, 0, 32'h0,        8'h00};
    tbl[11] = '{1'b1, 32'h1000, 32'h11223344, 4'h9, 1, 1, 2'b00, 1'b1, 0, 32'h11000044, 8'h01};
    tbl[12] = '{1'b0, 32'h1000, 32'h0,        4'h0, 0, 2, 2'b00, 1'b1, 0, 32'h11000044, 8'h00};
    tbl[13] = '{1'b1, 32'h1014, 32'h0,        4'h0, 2, 2, 2'b00, 1'b1, 5, 32'h0,        8'h20};

    for (int k = 0; k < NR; k++) begin
      m_regs[k] = RST;
      status_p[k] = 32'h0100_0000 * k + 32'h33;
    end
    status_p[2] = 32'hA5A5A5A5;

    // Reset behaviour
    repeat (3) @(negedge aclk);
    chk("rst_awready", s_axil_awready, 0);
    chk("rst_wready", s_axil_wready, 0);
    chk("rst_arready", s_axil_arready, 0);
    areset = 0;
    #1;
    chk("rst_bvalid", s_axil_bvalid, 0);
    chk("rst_rvalid", s_axil_rvalid, 0);
    chk("rst_bresp", s_axil_bresp, 0);
    chk("rst_rresp", s_axil_rresp, 0);
    chk("rst_rdata", s_axil_rdata, 0);
    chk("rst_pulse", reg_wr_pulse, 0);
    chk_regs("rst_regs");
    chk("idle_awready", s_axil_awready, 1);
    chk("idle_arready", s_axil_arready, 1);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].is_wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].aw_dly, tbl[i].w_dly, 0, r, p);
        chk("tbl_bresp", r, tbl[i].exp_resp);
        chk("tbl_pulse", p, tbl[i].exp_pulse);
        if (tbl[i].chk_val) chk("tbl_reg", reg_q[tbl[i].idx*32 +: 32], tbl[i].exp_val);
      end else begin
        do_read(tbl[i].addr, tbl[i].aw_dly, tbl[i].w_dly, d, r);
        chk("tbl_rresp", r, tbl[i].exp_resp);
        chk("tbl_rdata", d, tbl[i].exp_val);
      end
    end

    // Stall B and R for 5 cycles
    @(negedge aclk);
    m_read(BASE + 4, ed, er);
    m_write(BASE + 20, 32'h0000_0055, 4'hF, r, ep);
    s_axil_awaddr = BASE + 20; s_axil_wdata = 32'h55; s_axil_wstrb = 4'hF; s_axil_araddr = BASE + 4;
    s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_arvalid = 1; s_axil_bready = 0; s_axil_rready = 0;
    @(negedge aclk);
    s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
    chk("stall_pulse", reg_wr_pulse, ep);
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid", s_axil_bvalid, 1);
      chk("stall_bresp", s_axil_bresp, r);
      chk("stall_rvalid", s_axil_rvalid, 1);
      chk("stall_rdata", s_axil_rdata, ed);
      chk("stall_rresp", s_axil_rresp, er);
      chk("stall_awready", s_axil_awready, 0);
      chk("stall_wready", s_axil_wready, 0);
      chk("stall_arready", s_axil_arready, 0);
      @(negedge aclk);
    end
    s_axil_bready = 1; s_axil_rready = 1;
    @(negedge aclk);
    s_axil_bready = 0; s_axil_rready = 0;
    chk("stall_bvalid_drop", s_axil_bvalid, 0);
    chk("stall_rvalid_drop", s_axil_rvalid, 0);
    chk_regs("stall_regs");

    // Same-edge read and write of reg3: read sees the old value
    m_read(BASE + 12, ed, er);
    m_write(BASE + 12, 32'h7, 4'hF, r, ep);
    s_axil_awaddr = BASE + 12; s_axil_wdata = 32'h7; s_axil_wstrb = 4'hF; s_axil_araddr = BASE + 12;
    s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_arvalid = 1; s_axil_bready = 1; s_axil_rready = 1;
    @(negedge aclk);
    s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
    chk("same_rvalid", s_axil_rvalid, 1);
    chk("same_rdata_old", s_axil_rdata, 32'h0);
    chk("same_rdata_model", s_axil_rdata, ed);
    chk("same_bvalid", s_axil_bvalid, 1);
    chk("same_reg3", reg_q[3*32 +: 32], 32'h7);
    @(negedge aclk);
    s_axil_bready = 0; s_axil_rready = 0;
    chk("same_rvalid_drop", s_axil_rvalid, 0);
    chk("same_bvalid_drop", s_axil_bvalid, 0);
    do_read(BASE + 12, 0, 0, d, r);
    chk("same_next_read", d, 32'h7);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = BASE - 8 + 4 * $urandom_range(0, 12) + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) status_p[$urandom_range(0, NR-1)] = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), r, p);
      else
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), d, r);
    end

    // Reset while a B response is pending
    @(negedge aclk);
    s_axil_awaddr = BASE + 16; s_axil_wdata = 32'h44; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_bready = 0;
    @(negedge aclk);
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    chk("rstmid_bvalid_pre", s_axil_bvalid, 1);
    areset = 1;
    #1;
    chk("rstmid_awready", s_axil_awready, 0);
    chk("rstmid_wready", s_axil_wready, 0);
    chk("rstmid_arready", s_axil_arready, 0);
    @(negedge aclk);
    chk("rstmid_bvalid", s_axil_bvalid, 0);
    areset = 0;
    for (int k = 0; k < NR; k++) m_regs[k] = RST;
    #1;
    chk_regs("rstmid_regs");
    chk("rstmid_pulse", reg_wr_pulse, 0);
    chk("rstmid_awready_after", s_axil_awready, 1);
    do_write(BASE + 24, 32'h600D_CAFE, 4'hF, 0, 1, 1, r, p);
    do_read(BASE + 24, 0, 1, d, r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
